// File: rtl/pic16f84_x1_fetch_seq.sv
// Instruction-fetch sequencer for the PIC16F84 x1 core: Q1-Q4 phase generator,
// program counter, instruction register, 8-level circular return stack and pipeline flush.
module pic16f84_x1_fetch_seq #(
  parameter int unsigned PC_W        = 13,
  parameter int unsigned INST_W      = 14,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  output logic                           q1,
  output logic                           q2,
  output logic                           q3,
  output logic                           q4,
  output logic [PC_W-1:0]                pc_out,
  output logic                           nop_out,
  input  logic [INST_W-1:0]              rom_inst,
  output logic [INST_W-1:0]              ir_out,
  output logic                           ir_valid,
  input  logic                           jump_req,
  input  logic [PC_W-1:0]                jump_addr,
  input  logic                           call_req,
  input  logic                           ret_req,
  input  logic                           skip_req,
  output logic [$clog2(STACK_DEPTH)-1:0] stk_ptr,
  output logic                           stk_ovf,
  output logic                           stk_unf
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {PH_Q1, PH_Q2, PH_Q3, PH_Q4} phase_e;

  phase_e              phase_q, phase_d;
  logic [3:0]          qs_q, qs_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                nop_q, nop_d;
  logic [INST_W-1:0]   ir_q, ir_d;
  logic                irv_q, irv_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W:0]      cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [PC_W-1:0]     stack_q [STACK_DEPTH];
  logic                push_en;
  logic [PTR_W-1:0]    ptr_dec;
  logic                cycle_end;

  always_comb begin
    phase_d   = phase_q;
    qs_d      = qs_q;
    pc_d      = pc_q;
    nop_d     = nop_q;
    ir_d      = ir_q;
    irv_d     = irv_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push_en   = 1'b0;
    ptr_dec   = ptr_q - 1'b1;
    cycle_end = en && (phase_q == PH_Q4);

    if (en) begin
      phase_d = phase_e'(phase_q + 2'd1);
      qs_d    = 4'b0001 << phase_d;
    end

    // Edge leaving Q4: latch fetched word, then pick next PC by priority ret > call > jump > skip.
    if (cycle_end) begin
      ir_d  = nop_q ? '0 : rom_inst;
      irv_d = ~nop_q;
      pc_d  = pc_q + 1'b1;
      nop_d = 1'b0;
      if (ret_req) begin
        ptr_d = ptr_dec;
        pc_d  = stack_q[ptr_dec];
        nop_d = 1'b1;
        if (cnt_q == '0) unf_d = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end else if (call_req) begin
        push_en = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        pc_d    = jump_addr;
        nop_d   = 1'b1;
        if (cnt_q == (PTR_W+1)'(STACK_DEPTH)) ovf_d = 1'b1;
        else                                   cnt_d = cnt_q + 1'b1;
      end else if (jump_req) begin
        pc_d  = jump_addr;
        nop_d = 1'b1;
      end else if (skip_req) begin
        nop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_Q1;
      qs_q    <= 4'b0001;
      pc_q    <= '0;
      nop_q   <= 1'b1;
      ir_q    <= '0;
      irv_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      qs_q    <= qs_d;
      pc_q    <= pc_d;
      nop_q   <= nop_d;
      ir_q    <= ir_d;
      irv_q   <= irv_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && push_en) stack_q[ptr_q] <= pc_q;
  end

  assign q1       = qs_q[0];
  assign q2       = qs_q[1];
  assign q3       = qs_q[2];
  assign q4       = qs_q[3];
  assign pc_out   = pc_q;
  assign nop_out  = nop_q;
  assign ir_out   = ir_q;
  assign ir_valid = irv_q;
  assign stk_ptr  = ptr_q;
  assign stk_ovf  = ovf_q;
  assign stk_unf  = unf_q;

endmodule
